mux_nway_reg: RTL and testbench

- Parametrised, registered N-to-1 datapath select stage with a valid/ready handshake on both sides.
- Selects one of NUM_IN flattened WIDTH-bit channels per accepted beat and registers the result behind a 2-entry skid buffer, so throughput is one beat per cycle with a registered in_ready.
- Out-of-range selects never infer latches: they replay the last good value and are flagged.
- Drops into core operand-forwarding and writeback select paths where a pipeline boundary is needed at the mux.

---
 rtl/mux_nway_reg.sv | 95 +++++++++
 tb/tb_mux_nway_reg.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mux_nway_reg.sv
// mux_nway_reg: registered N-to-1 channel select behind a 2-entry skid buffer with valid/ready on both sides.
// Optional select-error counter is built only when MUX_SEL_ERR_CNT_EN is defined; otherwise err_count is tied to 0.
module mux_nway_reg #(
    parameter int WIDTH = 32,
    parameter int NUM_IN = 3,
    parameter int ERR_CNT_W = 8,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    sel_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ERR_CNT_W-1:0]    err_count
);
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
    state_t state, next_state;
    logic [WIDTH-1:0] beat_data, main_data, skid_data, last_good;
    logic beat_err, main_err, skid_err, accept, emit;
    assign accept = in_valid && in_ready;
    assign emit = out_valid && out_ready;
    assign out_valid = state != EMPTY;
    assign out_data = main_data;
    assign sel_err = main_err;
    // channel select; codes with no matching channel replay the last good value
    always_comb begin
        beat_data = last_good;
        beat_err = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                beat_data = in_data[i*WIDTH +: WIDTH];
                beat_err = 1'b0;
            end
        end
    end
    // occupancy next-state: main register, then skid register
    always_comb begin
        next_state = state;
        case (state)
            EMPTY: next_state = accept ? FULL : EMPTY;
            FULL: next_state = (accept && !emit) ? SKID : (!accept && emit) ? EMPTY : FULL;
            SKID: next_state = emit ? FULL : SKID;
            default: next_state = EMPTY;
        endcase
    end
    // state register; in_ready is registered from the next state so out_ready never reaches it combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            in_ready <= 1'b0;
        end else begin
            state <= next_state;
            in_ready <= next_state != SKID;
        end
    end
    // datapath: main feeds the output, skid absorbs one beat under backpressure, last_good tracks valid selects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data <= '0;
            main_err <= 1'b0;
            skid_data <= '0;
            skid_err <= 1'b0;
            last_good <= '0;
        end else begin
            if (state == SKID && emit) begin
                main_data <= skid_data;
                main_err <= skid_err;
            end else if (accept && (state == EMPTY || emit)) begin
                main_data <= beat_data;
                main_err <= beat_err;
            end
            if (accept && state == FULL && !emit) begin
                skid_data <= beat_data;
                skid_err <= beat_err;
            end
            if (accept && !beat_err) last_good <= beat_data;
        end
    end
`ifdef MUX_SEL_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;
    assign err_count = err_cnt_q;
    // saturating count of accepted out-of-range beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= '0;
        else if (accept && beat_err && err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
`else
    assign err_count = '0;
`endif
endmodule

// File: tb/tb_mux_nway_reg.sv
// tb_mux_nway_reg: directed self-checking bench for mux_nway_reg (WIDTH=32, NUM_IN=3, ERR_CNT_W=2).
module tb_mux_nway_reg;
    logic clk = 1'b0;
    logic rst_n;
    logic [95:0] in_data;
    logic [1:0] sel;
    logic in_valid, in_ready, out_valid, out_ready, sel_err;
    logic [31:0] out_data;
    logic [1:0] err_count;
    int checks = 0;
    int errors = 0;
`ifdef MUX_SEL_ERR_CNT_EN
    localparam bit cnt_en = 1'b1;
`else
    localparam bit cnt_en = 1'b0;
`endif
    mux_nway_reg #(.WIDTH(32), .NUM_IN(3), .ERR_CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .sel_err(sel_err), .out_valid(out_valid),
        .out_ready(out_ready), .err_count(err_count)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    initial begin
        logic [31:0] stream_exp [3];
        stream_exp[0] = 32'h11111111;
        stream_exp[1] = 32'h22222222;
        stream_exp[2] = 32'h33333333;
        rst_n = 1'b0;
        in_valid = 1'b1;
        sel = 2'd0;
        out_ready = 1'b1;
        in_data = {32'h33333333, 32'h22222222, 32'h11111111};
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_sel_err", 64'(sel_err), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            @(negedge clk);
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_data", 64'(out_data), 64'(stream_exp[k]));
            check("stream_sel_err", 64'(sel_err), 64'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_drained", 64'(out_valid), 64'd0);
        in_data = {32'h33333333, 32'hAAAA5555, 32'h11111111};
        in_valid = 1'b1;
        sel = 2'd1;
        @(negedge clk);
        check("replay_first_data", 64'(out_data), 64'hAAAA5555);
        check("replay_first_err", 64'(sel_err), 64'd0);
        sel = 2'd3;
        @(negedge clk);
        check("replay_data", 64'(out_data), 64'hAAAA5555);
        check("replay_err", 64'(sel_err), 64'd1);
        check("replay_err_count", 64'(err_count), cnt_en ? 64'd1 : 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        check("replay_drained", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        in_valid = 1'b1;
        sel = 2'd0;
        in_data[31:0] = 32'hA0A0A0A0;
        @(negedge clk);
        check("bp_a_main", 64'(out_data), 64'hA0A0A0A0);
        check("bp_a_ready", 64'(in_ready), 64'd1);
        in_data[31:0] = 32'hB0B0B0B0;
        @(negedge clk);
        check("bp_skid_ready", 64'(in_ready), 64'd0);
        check("bp_skid_valid", 64'(out_valid), 64'd1);
        check("bp_stable_1", 64'(out_data), 64'hA0A0A0A0);
        in_data[31:0] = 32'hC0C0C0C0;
        @(negedge clk);
        check("bp_stable_2", 64'(out_data), 64'hA0A0A0A0);
        check("bp_held_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_b_out", 64'(out_data), 64'hB0B0B0B0);
        check("bp_b_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("bp_c_out", 64'(out_data), 64'hC0C0C0C0);
        check("bp_c_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_drained", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        in_valid = 1'b1;
        sel = 2'd1;
        repeat (2) @(negedge clk);
        check("pre_rst_skid_ready", 64'(in_ready), 64'd0);
        check("pre_rst_skid_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_ready", 64'(in_ready), 64'd0);
        check("async_rst_err_count", 64'(err_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("rerst_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        sel = 2'd3;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            check("sat_data", 64'(out_data), 64'd0);
            check("sat_err", 64'(sel_err), 64'd1);
            check("sat_count", 64'(err_count), cnt_en ? 64'((n > 3) ? 3 : n) : 64'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("final_drained", 64'(out_valid), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
